// File: rtl/gray_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gray_conv_arbiter
// Description : Round-robin sharing of one external binary/Gray converter
//               between two requesters, with per-channel valid/ready results.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_conv_arbiter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             mode0,
    input  logic             mode1,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rsp_valid0,
    output logic             rsp_valid1,
    input  logic             rsp_ready0,
    input  logic             rsp_ready1,
    output logic [WIDTH-1:0] rsp_data,
    output logic             conv_chooser,
    output logic [WIDTH-1:0] conv_in,
    input  logic [WIDTH-1:0] conv_out,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_last_grant;
    logic             w_last_grant_nxt;
    logic             r_gnt0, r_gnt1;
    logic             w_gnt0_nxt, w_gnt1_nxt;
    logic             r_rsp_valid0, r_rsp_valid1;
    logic             w_rsp_valid0_nxt, w_rsp_valid1_nxt;
    logic [WIDTH-1:0] r_rsp_data;
    logic [WIDTH-1:0] w_rsp_data_nxt;
    logic             r_conv_chooser;
    logic             w_conv_chooser_nxt;
    logic [WIDTH-1:0] r_conv_in;
    logic [WIDTH-1:0] w_conv_in_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic [CNT_W-1:0] r_done_cnt;
    logic [CNT_W-1:0] w_done_cnt_nxt;

    logic             w_grant;
    logic             w_pick1;
    logic             w_accept;

    // On a tie the channel that did not win last time is served; last_grant
    // also names the channel that owns the in-flight transaction.
    always_comb begin
        w_grant  = (r_state == S_IDLE) && (req0 || req1);
        w_pick1  = (req0 && req1) ? ~r_last_grant : req1;
        w_accept = (r_state == S_RESP) && (r_last_grant ? rsp_ready1 : rsp_ready0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant)  w_state_nxt = S_DRIVE;
            S_DRIVE: w_state_nxt = S_RESP;
            S_RESP:  if (w_accept) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_gnt0_nxt         = 1'b0;
        w_gnt1_nxt         = 1'b0;
        w_last_grant_nxt   = r_last_grant;
        w_rsp_valid0_nxt   = r_rsp_valid0;
        w_rsp_valid1_nxt   = r_rsp_valid1;
        w_rsp_data_nxt     = r_rsp_data;
        w_conv_chooser_nxt = r_conv_chooser;
        w_conv_in_nxt      = r_conv_in;
        w_done_cnt_nxt     = r_done_cnt;
        w_busy_nxt         = (w_state_nxt != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_gnt0_nxt         = ~w_pick1;
                    w_gnt1_nxt         = w_pick1;
                    w_last_grant_nxt   = w_pick1;
                    w_conv_chooser_nxt = w_pick1 ? mode1 : mode0;
                    w_conv_in_nxt      = w_pick1 ? din1 : din0;
                end
            end
            S_DRIVE: begin
                w_rsp_data_nxt   = conv_out;
                w_rsp_valid0_nxt = ~r_last_grant;
                w_rsp_valid1_nxt = r_last_grant;
            end
            S_RESP: begin
                if (w_accept) begin
                    w_rsp_valid0_nxt = 1'b0;
                    w_rsp_valid1_nxt = 1'b0;
                    w_done_cnt_nxt   = r_done_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_rsp_valid0_nxt = 1'b0;
                w_rsp_valid1_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant   <= 1'b1;
            r_gnt0         <= 1'b0;
            r_gnt1         <= 1'b0;
            r_rsp_valid0   <= 1'b0;
            r_rsp_valid1   <= 1'b0;
            r_rsp_data     <= '0;
            r_conv_chooser <= 1'b0;
            r_conv_in      <= '0;
            r_busy         <= 1'b0;
            r_done_cnt     <= '0;
        end else begin
            r_last_grant   <= w_last_grant_nxt;
            r_gnt0         <= w_gnt0_nxt;
            r_gnt1         <= w_gnt1_nxt;
            r_rsp_valid0   <= w_rsp_valid0_nxt;
            r_rsp_valid1   <= w_rsp_valid1_nxt;
            r_rsp_data     <= w_rsp_data_nxt;
            r_conv_chooser <= w_conv_chooser_nxt;
            r_conv_in      <= w_conv_in_nxt;
            r_busy         <= w_busy_nxt;
            r_done_cnt     <= w_done_cnt_nxt;
        end
    end

    assign gnt0         = r_gnt0;
    assign gnt1         = r_gnt1;
    assign rsp_valid0   = r_rsp_valid0;
    assign rsp_valid1   = r_rsp_valid1;
    assign rsp_data     = r_rsp_data;
    assign conv_chooser = r_conv_chooser;
    assign conv_in      = r_conv_in;
    assign busy         = r_busy;
    assign done_cnt     = r_done_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gray_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_conv_arbiter
// Description : Self-checking bench for gray_conv_arbiter with an external
//               converter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_conv_arbiter;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1, mode0, mode1;
    logic [WIDTH-1:0] din0, din1;
    logic             gnt0, gnt1, rsp_valid0, rsp_valid1;
    logic             rsp_ready0, rsp_ready1;
    logic [WIDTH-1:0] rsp_data;
    logic             conv_chooser;
    logic [WIDTH-1:0] conv_in, conv_out;
    logic             busy;
    logic [CNT_W-1:0] done_cnt;

    int total = 0;
    int bad   = 0;
    int model_cnt = 0;

    always #5 clk = ~clk;

    gray_conv_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .mode0(mode0), .mode1(mode1),
        .din0(din0), .din1(din1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
        .rsp_data(rsp_data),
        .conv_chooser(conv_chooser), .conv_in(conv_in), .conv_out(conv_out),
        .busy(busy), .done_cnt(done_cnt)
    );

    function automatic logic [WIDTH-1:0] b2g(input logic [WIDTH-1:0] x);
        return x ^ (x >> 1);
    endfunction

    // Gray->binary by searching for the binary code whose Gray image matches.
    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] r = '0;
        for (int b = 0; b < (1 << WIDTH); b++)
            if (b2g(WIDTH'(b)) == g) r = WIDTH'(b);
        return r;
    endfunction

    assign conv_out = conv_chooser ? b2g(conv_in) : g2b(conv_in);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic gnt_of(input int ch);
        return ch == 0 ? gnt0 : gnt1;
    endfunction

    function automatic logic val_of(input int ch);
        return ch == 0 ? rsp_valid0 : rsp_valid1;
    endfunction

    task automatic set_req(input int ch, input logic r, input logic md, input logic [WIDTH-1:0] d);
        if (ch == 0) begin req0 = r; mode0 = md; din0 = d; end
        else         begin req1 = r; mode1 = md; din1 = d; end
    endtask

    task automatic set_ready(input int ch, input logic r);
        if (ch == 0) rsp_ready0 = r; else rsp_ready1 = r;
    endtask

    // Single transaction from an idle block; other channel's ready is waved
    // during the hold phase to show it is ignored.
    task automatic run_txn(input int ch, input logic md, input logic [WIDTH-1:0] d,
                           input logic [WIDTH-1:0] exp, input int hold,
                           output logic [WIDTH-1:0] got);
        int n = 0;
        got = '0;
        set_req(ch, 1'b1, md, d);
        do begin @(negedge clk); n++; end while (!gnt_of(ch) && n < 20);
        chk("gnt_seen", gnt_of(ch), 1);
        if (!gnt_of(ch)) begin set_req(ch, 1'b0, md, d); return; end
        chk("gnt_latency", n, 1);
        chk("gnt_other", gnt_of(1 - ch), 0);
        chk("chooser", conv_chooser, md);
        chk("conv_in", conv_in, d);
        chk("busy_drive", busy, 1);
        set_req(ch, 1'b0, ~md, ~d);
        @(negedge clk);
        chk("gnt_pulse", gnt_of(ch), 0);
        chk("valid", val_of(ch), 1);
        chk("valid_other", val_of(1 - ch), 0);
        chk("rsp_data", rsp_data, exp);
        chk("conv_hold", {conv_chooser, conv_in}, {md, d});
        got = rsp_data;
        set_ready(1 - ch, 1'b1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", val_of(ch), 1);
            chk("hold_data", rsp_data, exp);
        end
        set_ready(1 - ch, 1'b0);
        set_ready(ch, 1'b1);
        @(negedge clk);
        set_ready(ch, 1'b0);
        model_cnt = (model_cnt + 1) % (1 << CNT_W);
        chk("valid_clr", {rsp_valid0, rsp_valid1}, 0);
        chk("done_cnt", done_cnt, model_cnt);
        chk("busy_idle", busy, 0);
    endtask

    typedef struct {
        int               ch;
        logic             md;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] exp;
        int               hold;
    } vec_t;

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_cnt = 0;
        @(negedge clk);
    endtask

    initial begin
        vec_t             vecs[6];
        logic [WIDTH-1:0] got, g, b;
        logic             seen;
        int               ch, hold;
        logic             md;
        logic [WIDTH-1:0] d;

        vecs[0] = '{0, 1'b1, 4'b0101, 4'b0111, 0};
        vecs[1] = '{1, 1'b0, 4'b1111, 4'b1010, 1};
        vecs[2] = '{0, 1'b1, 4'b1000, 4'b1100, 2};
        vecs[3] = '{1, 1'b0, 4'b0110, 4'b0100, 0};
        vecs[4] = '{1, 1'b1, 4'b1111, 4'b1000, 3};
        vecs[5] = '{0, 1'b0, 4'b0001, 4'b0001, 1};

        req0 = 0; req1 = 0; mode0 = 0; mode1 = 0; din0 = '0; din1 = '0;
        rsp_ready0 = 0; rsp_ready1 = 0;
        do_reset();
        chk("reset_outs", {gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_data, conv_chooser, conv_in, busy, done_cnt}, 0);

        // Both channels request together right after reset: 0 first, then alternate.
        req0 = 1; mode0 = 1; din0 = 4'b1000;
        req1 = 1; mode1 = 0; din1 = 4'b0110;
        rsp_ready0 = 1; rsp_ready1 = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ch = (i / 3) % 2;
            case (i % 3)
                0: chk("alt_gnt", {gnt_of(ch), gnt_of(1 - ch)}, 2'b10);
                1: begin
                    chk("alt_valid", {val_of(ch), val_of(1 - ch)}, 2'b10);
                    chk("alt_data", rsp_data, ch == 0 ? 4'b1100 : 4'b0100);
                end
                default: chk("alt_idle", {rsp_valid0, rsp_valid1, busy}, 0);
            endcase
        end
        req0 = 0; req1 = 0; rsp_ready0 = 0; rsp_ready1 = 0;
        model_cnt = 4;
        chk("alt_cnt", done_cnt, model_cnt);

        foreach (vecs[i])
            run_txn(vecs[i].ch, vecs[i].md, vecs[i].din, vecs[i].exp, vecs[i].hold, got);

        // Channel 1 arrives while channel 0 sits in RESP for 5 cycles.
        req0 = 1; mode0 = 0; din0 = 4'b1111;
        @(negedge clk);
        chk("t4_gnt0", gnt0, 1);
        req0 = 0;
        req1 = 1; mode1 = 1; din1 = 4'b0011;
        @(negedge clk);
        chk("t4_valid0", rsp_valid0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold", {rsp_valid0, rsp_data, gnt1}, {1'b1, 4'b1010, 1'b0});
        end
        rsp_ready0 = 1;
        @(negedge clk);
        rsp_ready0 = 0;
        model_cnt++;
        chk("t4_accept", {rsp_valid0, gnt1, done_cnt}, {2'b00, 8'(model_cnt)});
        @(negedge clk);
        chk("t4_gnt1", gnt1, 1);
        chk("t4_conv", {conv_chooser, conv_in}, {1'b1, 4'b0011});
        req1 = 0;
        @(negedge clk);
        chk("t4_data1", {rsp_valid1, rsp_data}, {1'b1, 4'b0010});
        rsp_ready1 = 1;
        @(negedge clk);
        rsp_ready1 = 0;
        model_cnt++;
        chk("t4_cnt", done_cnt, model_cnt);

        // Asynchronous reset while the conversion is in DRIVE.
        req0 = 1; mode0 = 1; din0 = 4'b0110;
        @(negedge clk);
        chk("t5_gnt", gnt0, 1);
        req0 = 0;
        rst = 1;
        #1;
        chk("t5_outs", {gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_data, conv_chooser, conv_in, busy, done_cnt}, 0);
        @(negedge clk);
        rst = 0;
        model_cnt = 0;
        seen = 0;
        rsp_ready0 = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen = seen | rsp_valid0 | rsp_valid1 | busy;
        end
        rsp_ready0 = 0;
        chk("t5_no_rsp", seen, 0);
        chk("t5_cnt", done_cnt, 0);

        // Full sweep through channel 0 with round trip through the DUT.
        for (int x = 0; x < (1 << WIDTH); x++) begin
            run_txn(0, 1'b1, WIDTH'(x), b2g(WIDTH'(x)), 0, g);
            run_txn(0, 1'b0, g, g2b(g), 0, b);
            chk("roundtrip", b, x);
        end
        chk("sweep_cnt", done_cnt, 32);

        // Random traffic, long enough to wrap the done counter.
        for (int i = 0; i < 240; i++) begin
            ch   = int'($urandom_range(0, 1));
            md   = 1'($urandom_range(0, 1));
            d    = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            hold = int'($urandom_range(0, 2));
            run_txn(ch, md, d, md ? b2g(d) : g2b(d), hold, got);
        end
        chk("wrap_cnt", done_cnt, (32 + 240) % 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
